// File: rtl/frame_generator_param.sv
// frame_generator_param: byte-stream frame generator.
// Payload is written into an internal buffer while idle. On start the block
// streams preamble, payload, zero padding up to a minimum length and an
// optional additive checksum over a valid/ready interface with a last marker.
module frame_generator_param #(
  parameter int                DATA_W        = 8,
  parameter int                MAX_LEN       = 64,
  parameter int                MIN_LEN       = 16,
  parameter int                PREAMBLE_LEN  = 2,
  parameter logic [DATA_W-1:0] PREAMBLE_BYTE = DATA_W'(8'h55),
  parameter logic [DATA_W-1:0] PAD_BYTE      = DATA_W'(8'h00),
  parameter int                CHK_EN        = 1,
  localparam int               AW            = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
  localparam int               LW            = $clog2(MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic [LW-1:0]     len,
  output logic [DATA_W-1:0] frame_data,
  output logic              valid,
  input  logic              ready,
  output logic              last,
  output logic              busy,
  output logic              err
);

  // Position counter must cover both the preamble count and payload+pad count.
  localparam int PW = $clog2(PREAMBLE_LEN + 1);
  localparam int CW = (LW > PW) ? LW : PW;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    PAY  = 3'd2,
    PAD  = 3'd3,
    CHK  = 3'd4
  } state_t;

  // A word position: which section of the frame and the index within it.
  // In PAD the index keeps counting from len so it compares against MIN_LEN.
  typedef struct packed {
    state_t        seg;
    logic [CW-1:0] idx;
  } pos_t;

  localparam pos_t POS_END = '{seg: IDLE, idx: '0};

  // Position of the word that follows cur in a frame of payload length l.
  // Empty sections are skipped, so the result is always a word that exists
  // or POS_END when the frame is over.
  function automatic pos_t step(input pos_t cur, input logic [CW-1:0] l);
    pos_t p;
    p = cur;
    case (cur.seg)
      IDLE: begin
        p.seg = PRE;
        p.idx = '0;
      end
      PRE: begin
        if (cur.idx + CW'(1) < CW'(PREAMBLE_LEN)) begin
          p.idx = cur.idx + CW'(1);
        end else begin
          p.seg = PAY;
          p.idx = '0;
        end
      end
      PAY: begin
        if (cur.idx + CW'(1) < l) begin
          p.idx = cur.idx + CW'(1);
        end else begin
          p.seg = PAD;
          p.idx = l;
        end
      end
      PAD: begin
        p.idx = cur.idx + CW'(1);
      end
      default: begin
        p = POS_END;
      end
    endcase
    if (p.seg == PRE && PREAMBLE_LEN == 0) begin
      p.seg = PAY;
      p.idx = '0;
    end
    if (p.seg == PAY && l == '0) begin
      p.seg = PAD;
      p.idx = '0;
    end
    if (p.seg == PAD && p.idx >= CW'(MIN_LEN)) begin
      p.seg = CHK;
      p.idx = '0;
    end
    if (p.seg == CHK && CHK_EN == 0) begin
      p = POS_END;
    end
    return p;
  endfunction

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [CW-1:0]       len_q, len_d;
  logic [DATA_W-1:0]   chk_q, chk_d;
  logic [DATA_W-1:0]   frame_data_q, frame_data_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;

  logic [DATA_W-1:0]   mem [MAX_LEN];
  logic [DATA_W-1:0]   rd_data_q;
  logic [AW-1:0]       rd_addr;
  logic [CW-1:0]       rd_next;
  logic                wr_addr_ok;
  logic                wr_ok;

  // Addresses beyond a non power-of-two buffer are dropped.
  if (MAX_LEN == (1 << AW)) begin : g_addr_full
    assign wr_addr_ok = 1'b1;
  end else begin : g_addr_part
    assign wr_addr_ok = (32'(wr_addr) < MAX_LEN);
  end

  // The buffer is frozen for the whole frame so payload cannot tear.
  assign wr_ok = wr_en && !busy_q && wr_addr_ok;

  // Frame sequencing: compute the next presented word whenever a word is
  // accepted downstream or a start is taken.
  always_comb begin
    logic [CW-1:0]     len_ext;
    logic [CW-1:0]     l_eff;
    logic              start_ok;
    logic              start_bad;
    logic              advance;
    logic [DATA_W-1:0] chk_base;
    logic [DATA_W-1:0] pay_word;
    logic [DATA_W-1:0] word;
    pos_t              cur;
    pos_t              nxt;
    pos_t              after;

    state_d      = state_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    chk_d        = chk_q;
    frame_data_d = frame_data_q;
    valid_d      = valid_q;
    last_d       = last_q;
    busy_d       = busy_q;
    err_d        = 1'b0;

    len_ext   = CW'(len);
    l_eff     = (state_q == IDLE) ? len_ext : len_q;
    start_ok  = (state_q == IDLE) && start && (len <= LW'(MAX_LEN));
    start_bad = (state_q == IDLE) && start && (len > LW'(MAX_LEN));
    advance   = start_ok || (valid_q && ready);

    cur.seg = state_q;
    cur.idx = cnt_q;
    nxt     = step(cur, l_eff);
    after   = step(nxt, l_eff);

    // A new frame starts its checksum from zero.
    chk_base = (state_q == IDLE) ? '0 : chk_q;
    // Without a preamble the first payload word is loaded on the start edge;
    // a same-cycle write to address 0 must win over the stale read.
    pay_word = (state_q == IDLE && wr_ok && wr_addr == '0) ? wr_data : rd_data_q;

    case (nxt.seg)
      PRE:     word = PREAMBLE_BYTE;
      PAY:     word = pay_word;
      PAD:     word = PAD_BYTE;
      CHK:     word = chk_base;
      default: word = '0;
    endcase

    if (advance) begin
      state_d      = nxt.seg;
      cnt_d        = nxt.idx;
      frame_data_d = word;
      valid_d      = (nxt.seg != IDLE);
      busy_d       = (nxt.seg != IDLE);
      last_d       = (nxt.seg != IDLE) && (after == POS_END);
      chk_d        = chk_base;
      if (nxt.seg == PAY || nxt.seg == PAD) begin
        chk_d = chk_base + word;
      end
    end

    if (start_ok) begin
      len_d = len_ext;
    end
    err_d = start_bad;
  end

  // Read address runs one word ahead of the output so payload streams
  // back-to-back through the registered buffer read.
  always_comb begin
    rd_next = cnt_d + CW'(1);
    rd_addr = '0;
    if (state_d == PAY && rd_next < CW'(MAX_LEN)) begin
      rd_addr = rd_next[AW-1:0];
    end
  end

  // Payload buffer with registered, write-first read; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
    if (wr_ok && wr_addr == rd_addr) begin
      rd_data_q <= wr_data;
    end else begin
      rd_data_q <= mem[rd_addr];
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      len_q        <= '0;
      chk_q        <= '0;
      frame_data_q <= '0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      chk_q        <= chk_d;
      frame_data_q <= frame_data_d;
      valid_q      <= valid_d;
      last_q       <= last_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign frame_data = frame_data_q;
  assign valid      = valid_q;
  assign last       = last_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

// File: tb/tb_frame_generator_param.sv
// Testbench for frame_generator_param with default parameters.
module tb_frame_generator_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;
  logic       start;
  logic [6:0] len_i;
  logic [7:0] frame_data;
  logic       valid;
  logic       ready;
  logic       last;
  logic       busy;
  logic       err;

  always #5 clk = ~clk;

  frame_generator_param dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start      (start),
    .len        (len_i),
    .frame_data (frame_data),
    .valid      (valid),
    .ready      (ready),
    .last       (last),
    .busy       (busy),
    .err        (err)
  );

  typedef struct {
    int         load_set;
    int         l;
    int         rmode;
    int         exp_n;
    logic [7:0] exp_pay0;
    logic [7:0] exp_chk;
  } vec_t;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] mem_m [64];
  logic [7:0] got_q [$];
  bit         got_last [$];
  logic [7:0] exp_q [$];
  int         err_seen;
  int         stall_bad;
  bit         frame_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_buf(input int a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = 6'(a);
    wr_data = d;
    tick();
    wr_en   = 1'b0;
    mem_m[a] = d;
  endtask

  function automatic bit rdy_for(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return (cyc % 4 == 0) || (cyc % 4 == 3);
      default: return ($urandom_range(0, 3) != 0);
    endcase
  endfunction

  // Reference frame: two 0x55, payload, zeros up to 16 words, then the sum.
  task automatic build_expected(input int l);
    logic [7:0] s;
    logic [7:0] w;
    exp_q.delete();
    s = 8'h00;
    for (int i = 0; i < 2; i++) exp_q.push_back(8'h55);
    for (int i = 0; i < 16 || i < l; i++) begin
      w = (i < l) ? mem_m[i] : 8'h00;
      exp_q.push_back(w);
      s = s + w;
    end
    exp_q.push_back(s);
  endtask

  task automatic run_frame(input int l, input int rmode, input int inject_at,
                           input bit ws_en, input logic [7:0] ws_data);
    int         cyc;
    logic [7:0] pd;
    bit         pl;
    bit         stalled;
    got_q.delete();
    got_last.delete();
    err_seen   = 0;
    stall_bad  = 0;
    frame_done = 1'b0;
    if (ws_en) begin
      wr_en    = 1'b1;
      wr_addr  = 6'd0;
      wr_data  = ws_data;
      mem_m[0] = ws_data;
    end
    start = 1'b1;
    len_i = 7'(l);
    ready = 1'b0;
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("valid_after_start", 32'(valid), 32'd1);
    cyc = 0;
    stalled = 1'b0;
    pd = 8'h00;
    pl = 1'b0;
    while (!frame_done && cyc < 500) begin
      ready = rdy_for(rmode, cyc);
      if (cyc == inject_at) begin
        wr_en   = 1'b1;
        wr_addr = 6'd0;
        wr_data = 8'h77;
        start   = 1'b1;
        len_i   = 7'd16;
      end
      @(negedge clk);
      if (err) err_seen++;
      if (stalled && (!valid || frame_data !== pd || last !== pl)) stall_bad++;
      if (valid && ready) begin
        got_q.push_back(frame_data);
        got_last.push_back(last);
        if (last) frame_done = 1'b1;
      end
      stalled = valid && !ready;
      pd = frame_data;
      pl = last;
      tick();
      wr_en = 1'b0;
      start = 1'b0;
      cyc++;
    end
    ready = 1'b0;
    chk("frame_timeout", 32'(frame_done), 32'd1);
    chk("valid_after_last", 32'(valid), 32'd0);
    chk("busy_after_last", 32'(busy), 32'd0);
    chk("last_after_last", 32'(last), 32'd0);
  endtask

  task automatic compare_frame(input string name);
    chk($sformatf("%s_nwords", name), 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) begin
        chk($sformatf("%s_w%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
        chk($sformatf("%s_last%0d", name, i), 32'(got_last[i]),
            32'(i == exp_q.size() - 1));
      end
    end
    chk($sformatf("%s_stall_stable", name), 32'(stall_bad), 32'd0);
    chk($sformatf("%s_no_err", name), 32'(err_seen), 32'd0);
  endtask

  task automatic load_set_a();
    logic [7:0] set_a [16];
    set_a = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h01, 8'h02,
              8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
    for (int i = 0; i < 16; i++) write_buf(i, set_a[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs [5];
    int   n;
    int   cyc;
    int   l;
    vecs[0] = '{load_set: 1, l: 16, rmode: 0, exp_n: 19, exp_pay0: 8'hAA, exp_chk: 8'h32};
    vecs[1] = '{load_set: 0, l: 16, rmode: 1, exp_n: 19, exp_pay0: 8'hAA, exp_chk: 8'h32};
    vecs[2] = '{load_set: 0, l: 0,  rmode: 0, exp_n: 19, exp_pay0: 8'h00, exp_chk: 8'h00};
    vecs[3] = '{load_set: 2, l: 4,  rmode: 0, exp_n: 19, exp_pay0: 8'h01, exp_chk: 8'h0A};
    vecs[4] = '{load_set: 0, l: 4,  rmode: 1, exp_n: 19, exp_pay0: 8'h01, exp_chk: 8'h0A};

    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_addr = 6'd0;
    wr_data = 8'h00;
    start   = 1'b0;
    len_i   = 7'd0;
    ready   = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_last", 32'(last), 32'd0);
    chk("rst_data", 32'(frame_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    tick();
    reset = 1'b0;

    for (int a = 0; a < 64; a++) write_buf(a, 8'($urandom));

    // Directed table.
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].load_set == 1) load_set_a();
      if (vecs[v].load_set == 2) for (int i = 0; i < 4; i++) write_buf(i, 8'(i + 1));
      build_expected(vecs[v].l);
      run_frame(vecs[v].l, vecs[v].rmode, -1, 1'b0, 8'h00);
      compare_frame($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_count", v), 32'(got_q.size()), 32'(vecs[v].exp_n));
      chk($sformatf("vec%0d_pay0", v),
          (got_q.size() > 2) ? 32'(got_q[2]) : 32'hFFFF, 32'(vecs[v].exp_pay0));
      chk($sformatf("vec%0d_chk", v),
          (got_q.size() > 0) ? 32'(got_q[got_q.size() - 1]) : 32'hFFFF,
          32'(vecs[v].exp_chk));
      $display("vec%0d len=%0d ready_mode=%0d words=%0d", v, vecs[v].l, vecs[v].rmode, got_q.size());
    end

    // Rejected start.
    start = 1'b1;
    len_i = 7'd65;
    tick();
    start = 1'b0;
    chk("badlen_err", 32'(err), 32'd1);
    chk("badlen_valid", 32'(valid), 32'd0);
    chk("badlen_busy", 32'(busy), 32'd0);
    tick();
    chk("badlen_err_drop", 32'(err), 32'd0);
    chk("badlen_valid2", 32'(valid), 32'd0);
    chk("badlen_busy2", 32'(busy), 32'd0);
    $display("reject len=65 done");

    // Reset after five accepted words.
    load_set_a();
    start = 1'b1;
    len_i = 7'd16;
    tick();
    start = 1'b0;
    ready = 1'b1;
    n = 0;
    cyc = 0;
    while (n < 5 && cyc < 100) begin
      @(negedge clk);
      if (valid && ready) n++;
      tick();
      cyc++;
    end
    chk("rstmid_words", 32'(n), 32'd5);
    reset = 1'b1;
    ready = 1'b0;
    tick();
    reset = 1'b0;
    chk("rstmid_valid", 32'(valid), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_last", 32'(last), 32'd0);
    build_expected(16);
    run_frame(16, 0, -1, 1'b0, 8'h00);
    compare_frame("after_rst");
    $display("reset mid-frame then len=16 words=%0d", got_q.size());

    // Write and start during a frame are ignored.
    build_expected(16);
    run_frame(16, 0, 5, 1'b0, 8'h00);
    compare_frame("midwr");
    build_expected(16);
    run_frame(16, 0, -1, 1'b0, 8'h00);
    compare_frame("midwr_next");
    chk("midwr_next_pay0", (got_q.size() > 2) ? 32'(got_q[2]) : 32'hFFFF, 32'hAA);
    $display("write+start during frame words=%0d", got_q.size());

    // Write and start in the same idle cycle: new data is used.
    mem_m[0] = 8'h5A;
    build_expected(16);
    run_frame(16, 0, -1, 1'b1, 8'h5A);
    compare_frame("wrstart");
    chk("wrstart_pay0", (got_q.size() > 2) ? 32'(got_q[2]) : 32'hFFFF, 32'h5A);
    $display("write with start words=%0d", got_q.size());

    // Randomised frames against the reference model.
    for (int it = 0; it < 20; it++) begin
      n = $urandom_range(0, 8);
      for (int k = 0; k < n; k++) write_buf($urandom_range(0, 63), 8'($urandom));
      if ($urandom_range(0, 4) == 0) begin
        l = $urandom_range(65, 127);
        start = 1'b1;
        len_i = 7'(l);
        tick();
        start = 1'b0;
        chk("rnd_bad_err", 32'(err), 32'd1);
        chk("rnd_bad_valid", 32'(valid), 32'd0);
        tick();
        chk("rnd_bad_err_drop", 32'(err), 32'd0);
        $display("rnd%0d reject len=%0d", it, l);
      end else begin
        l = $urandom_range(0, 64);
        build_expected(l);
        run_frame(l, 2, -1, 1'b0, 8'h00);
        compare_frame($sformatf("rnd%0d", it));
        $display("rnd%0d len=%0d words=%0d", it, l, got_q.size());
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_generator_param.md
# frame_generator_param

Parametrised byte-stream frame generator. Payload is loaded into an internal buffer through a write port; on `start` the block emits preamble, payload, zero-padding up to a minimum frame length and an optional checksum trailer. Output is a valid/ready stream with a `last` marker. It sits between the payload-assembly logic and the serialiser/MAC-side transmit path.

## Interface

Parameters:
- `DATA_W`, 8: byte/lane width.
- `MAX_LEN`, 64: payload buffer depth in words; maximum accepted `len`.
- `MIN_LEN`, 16: minimum payload+pad length in words; must satisfy `MIN_LEN <= MAX_LEN`.
- `PREAMBLE_LEN`, 2: number of preamble words; 0 means no preamble.
- `PREAMBLE_BYTE`, 8'h55: preamble word value.
- `PAD_BYTE`, 8'h00: pad word value.
- `CHK_EN`, 1: 1 appends a checksum word; 0 omits it.
- Derived: `AW = clog2(MAX_LEN)`, `LW = clog2(MAX_LEN+1)`.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `wr_en` in 1: buffer write strobe.
- `wr_addr` in AW: buffer write address.
- `wr_data` in DATA_W: buffer write data.
- `start` in 1: frame request; sampled only in IDLE.
- `len` in LW: payload length in words, latched with `start`.
- `frame_data` out DATA_W: output word.
- `valid` out 1: `frame_data` is valid.
- `ready` in 1: downstream accepts the word when `valid && ready`.
- `last` out 1: marks the final word of the frame; qualified by `valid`.
- `busy` out 1: high from the cycle after an accepted start until the last handshake.
- `err` out 1: one-cycle pulse when a start is rejected.

## Operation

- States: IDLE, PRE, PAY, PAD, CHK.
- IDLE, `start=1`, `len <= MAX_LEN`: latch `len`, clear the word counter and checksum, then go to PRE. If `PREAMBLE_LEN=0`, go to PAY, or to PAD if `len=0`.
- IDLE, `start=1`, `len > MAX_LEN`: pulse `err` for 1 cycle, stay in IDLE, keep `valid=0`.
- PRE: emit `PREAMBLE_BYTE` `PREAMBLE_LEN` times, then go to PAY (or PAD if `len=0`).
- PAY: emit `buf[0..len-1]` in address order. Then go to PAD if `len < MIN_LEN`; otherwise go to CHK if `CHK_EN`, else IDLE.
- PAD: emit `PAD_BYTE` `(MIN_LEN - len)` times, then go to CHK or IDLE.
- CHK: emit the checksum, then go to IDLE.
- Checksum: sum mod 2^DATA_W of every PAY and PAD word. Preamble words are excluded.
- Total words per frame: `PREAMBLE_LEN + max(len, MIN_LEN) + CHK_EN`.
- `last` is high on the CHK word, or on the final PAY/PAD word when `CHK_EN=0`.
- Buffer is write-locked while `busy`: `wr_en` is ignored. In IDLE a write takes effect at the clock edge.
- `start` while busy is ignored; no `err` is raised.
- Buffer contents are not cleared by reset.

## Timing

- Reset values: `valid=0`, `last=0`, `frame_data=0`, `busy=0`, `err=0`; state IDLE. Reset mid-frame aborts the frame and outputs return to reset values on the next cycle.
- Outputs are registered. Start is accepted at edge N; at N+1 `valid=1`, `busy=1` and the first word is presented.
- Advance happens only on `valid && ready`. While `valid && !ready`, `frame_data`, `last` and `valid` hold stable.
- With `ready` held high: one word per cycle, no bubbles.
- On the last handshake edge: `valid`, `last` and `busy` go 0 and the state returns to IDLE. A `start` in the following cycle is accepted, so there is a minimum 1-cycle idle gap between frames.
- `err` is asserted in the cycle after the rejected `start`, for exactly 1 cycle.
- A write and a `start` in the same IDLE cycle: the write lands first, so the frame uses the new data.

## Test plan

Default parameters throughout.

- Write AA,BB,CC,DD,EE,FF,01..0A to addresses 0..15; `start` with `len=16`, `ready=1`.
  - Required: 19 consecutive words 55,55,AA..0A,32.
  - `last` only on 0x32; `busy` low the cycle after.
- Write 01,02,03,04; `len=4`.
  - Required: 55,55,01,02,03,04, then twelve 00, then 0A with `last`.
- Rerun the first scenario with `ready` pattern 1,0,0,1 repeating.
  - Required: identical word sequence.
  - `frame_data`/`last` stable during every stall; no word dropped or duplicated.
- `start` with `len=65`: `err` pulses 1 cycle, `valid` and `busy` stay 0.
- `start` with `len=0`: required output is 55,55, sixteen 00, then 00 with `last`.
- Reset after 5 accepted words: next cycle `valid=0` and `busy=0`. A following `start` with `len=16` reproduces the first scenario exactly.
- During a frame, `wr_en` 0x77 to address 0 and pulse `start`.
  - Required: no effect on the current frame and no `err`.
  - The next frame still begins 55,55,AA.
